image_pixel_proc: RTL and testbench
===================================

IMAGE_PIXEL_PROC -- requirements
Module: image_pixel_proc

Interface
REQ-001 SHALL have parameter width_of_image, default 768, meaning pixels per line (even).
REQ-002 SHALL have parameter height_of_image, default 512, meaning lines per frame.
REQ-003 SHALL have parameter MODE, default 0, meaning operation (0 brightness add, 1 brightness subtract, 2 invert, 3 threshold).
REQ-004 SHALL have parameter VALUE, default 100, meaning brightness offset for modes 0/1.
REQ-005 SHALL have parameter THRESHOLD, default 90, meaning per-channel mean threshold for mode 3.
REQ-006 SHALL have parameter HBLANK, default 4, meaning idle cycles inserted between lines (1..255).
REQ-007 Ports, in order:
 HCLK  input  1  single clock, all logic on its rising edge.
 HRESET  input  1  asynchronous, active-high reset.
 start  input  1  one-cycle pulse; begins a frame.
 in_valid  input  1  upstream pixel pair present.
 in_ready  output  1  block accepts a pair this cycle.
 in_pix0  input  24  first pixel {R[23:16],G[15:8],B[7:0]}.
 in_pix1  input  24  second pixel, same packing.
 hsync  output  1  output pair valid this cycle.
 pixel_final_R0/G0/B0/R1/G1/B1  output  8 each  processed pair.
 busy  output  1  frame in progress.
 frame_done  output  1  one-cycle pulse after last pair of frame leaves.

Function
REQ-008 SHALL implement FSM IDLE, RUN, BLANK, DRAIN; reset state IDLE.
REQ-009 IDLE->RUN on start; start SHALL be ignored in any other state.
REQ-010 in_ready SHALL equal (state==RUN); a transfer is in_valid && in_ready.
REQ-011 Column counter SHALL count transfers 0..width_of_image/2-1, wrapping to 0 on the last column and incrementing the row counter (0..height_of_image-1).
REQ-012 On a last-column transfer of a non-last row, RUN->BLANK; BLANK SHALL hold exactly HBLANK cycles then return to RUN.
REQ-013 On the last-column transfer of the last row, RUN->DRAIN; DRAIN->IDLE after 2 cycles, asserting frame_done for exactly the cycle hsync carries the last pair.
REQ-014 Processing latency SHALL be exactly 2 cycles: transfer at cycle N -> hsync=1 with its result at cycle N+2; stage 1 registers inputs, stage 2 registers results.
REQ-015 hsync SHALL be 1 only for cycles carrying a transferred pair; pixel outputs SHALL hold last value when hsync=0.
REQ-016 Mode 0: each channel = min(ch+VALUE,255) using 9-bit intermediate.
REQ-017 Mode 1: each channel = max(ch-VALUE,0) using 9-bit signed intermediate.
REQ-018 Mode 2: each channel = 255-ch.
REQ-019 Mode 3: per pixel, 10-bit sum R+G+B > 3*THRESHOLD -> all channels 255, else all 0; equality gives 0.
REQ-020 busy SHALL be 1 in RUN, BLANK, DRAIN.
REQ-021 in_valid low in RUN SHALL stall counters without error; no timeout.

Reset
REQ-022 HRESET high SHALL asynchronously force state IDLE, counters 0, pipeline valid bits 0, in_ready, hsync, busy, frame_done and all pixel outputs 0.
REQ-023 Reset mid-frame SHALL abort; no frame_done, no further hsync until a new start after release.

Structure
REQ-024 Package image_proc_pkg SHALL hold mode encodings, FSM state enum, and 24-bit pixel typedef.
REQ-025 Sub-module pixel_op (combinational, one pixel in, one pixel out, MODE/VALUE/THRESHOLD parameters) SHALL be instantiated twice in stage 2.

Verification
REQ-026 MODE=0, VALUE=100, pix0=C8_32_0A -> R0=FF,G0=96,B0=6E at 2 cycles after transfer, hsync high that cycle only.
REQ-027 MODE=3, THRESHOLD=90, pix sum 270 -> 00_00_00; sum 271 -> FF_FF_FF.
REQ-028 width 8, height 2, HBLANK 4, in_valid held 1 -> in_ready pattern 4 high, 4 low, 4 high; frame_done 2 cycles after 8th transfer; 8 hsync pulses total.
REQ-029 start pulsed while busy -> ignored, counters unchanged; in_valid toggled 1/0 -> output order preserved, latency 2 per pair.
REQ-030 HRESET asserted after 3 transfers -> all outputs 0 immediately, no frame_done; fresh start yields complete frame of width*height/2 pairs.

Source files
------------

// File: rtl/image_proc_pkg.sv
// Shared types for the pixel-pair pipeline: operation codes, FSM states,
// pixel packing and the saturating channel helpers used by pixel_op.
package image_proc_pkg;

    typedef logic [23:0] pix_t;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_INV = 2'd2,
        MODE_THR = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_BLANK,
        ST_DRAIN
    } state_e;

    function automatic logic [7:0] sat_add(input logic [7:0] ch, input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, ch} + {1'b0, v};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // The sign bit of the 9-bit difference flags underflow.
    function automatic logic [7:0] sat_sub(input logic [7:0] ch, input logic [7:0] v);
        logic signed [8:0] d;
        d = $signed({1'b0, ch}) - $signed({1'b0, v});
        return d[8] ? 8'h00 : d[7:0];
    endfunction

endpackage

// File: rtl/pixel_op.sv
// Combinational per-pixel operation: brightness add/subtract, invert, or
// mean threshold to black/white, selected at elaboration by MODE.
module pixel_op
    import image_proc_pkg::*;
#(
    parameter int unsigned MODE      = 0,
    parameter int unsigned VALUE     = 100,
    parameter int unsigned THRESHOLD = 90
) (
    input  pix_t pix_i,
    output pix_t pix_o
);

    localparam logic [1:0] MODE_BITS = MODE[1:0];
    localparam mode_e      OP        = mode_e'(MODE_BITS);
    localparam logic [7:0] VAL8      = VALUE[7:0];
    localparam logic [9:0] THR3      = 10'(3 * THRESHOLD);

    logic [9:0] sum;

    assign sum = 10'(pix_i[23:16]) + 10'(pix_i[15:8]) + 10'(pix_i[7:0]);

    always_comb begin
        pix_o = '0;
        case (OP)
            MODE_ADD: begin
                for (int unsigned i = 0; i < 3; i++)
                    pix_o[i*8 +: 8] = sat_add(pix_i[i*8 +: 8], VAL8);
            end
            MODE_SUB: begin
                for (int unsigned i = 0; i < 3; i++)
                    pix_o[i*8 +: 8] = sat_sub(pix_i[i*8 +: 8], VAL8);
            end
            MODE_INV: pix_o = ~pix_i;
            MODE_THR: pix_o = (sum > THR3) ? '1 : '0;
            default:  pix_o = '0;
        endcase
    end

endmodule

// File: rtl/image_pixel_proc.sv
// Frame-sequenced pixel-pair processor: line/frame counting FSM with
// horizontal blanking, and a two-stage (capture, compute) output pipeline.
module image_pixel_proc
    import image_proc_pkg::*;
#(
    parameter int unsigned width_of_image  = 768,
    parameter int unsigned height_of_image = 512,
    parameter int unsigned MODE            = 0,
    parameter int unsigned VALUE           = 100,
    parameter int unsigned THRESHOLD       = 90,
    parameter int unsigned HBLANK          = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_pix0,
    input  logic [23:0] in_pix1,
    output logic        hsync,
    output logic [7:0]  pixel_final_R0,
    output logic [7:0]  pixel_final_G0,
    output logic [7:0]  pixel_final_B0,
    output logic [7:0]  pixel_final_R1,
    output logic [7:0]  pixel_final_G1,
    output logic [7:0]  pixel_final_B1,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned COLS  = width_of_image / 2;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W = (height_of_image > 1) ? $clog2(height_of_image) : 1;
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(height_of_image - 1);
    localparam logic [7:0]       LAST_BLANK = 8'(HBLANK - 1);

    state_e           state_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [7:0]       blank_q;
    logic             drain_q;

    logic xfer;
    logic last_pair;

    assign xfer      = in_valid && (state_q == ST_RUN);
    assign last_pair = (col_q == LAST_COL) && (row_q == LAST_ROW);
    assign in_ready  = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            blank_q <= '0;
            drain_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_q <= ST_RUN;
                ST_RUN: begin
                    if (xfer) begin
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            if (row_q == LAST_ROW) begin
                                row_q   <= '0;
                                drain_q <= 1'b0;
                                state_q <= ST_DRAIN;
                            end else begin
                                row_q   <= row_q + 1'b1;
                                blank_q <= '0;
                                state_q <= ST_BLANK;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                ST_BLANK: begin
                    if (blank_q == LAST_BLANK) state_q <= ST_RUN;
                    else                       blank_q <= blank_q + 1'b1;
                end
                ST_DRAIN: begin
                    if (drain_q) state_q <= ST_IDLE;
                    else         drain_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic s1_valid_q, s1_last_q;
    pix_t s1_pix0_q, s1_pix1_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_pix0_q  <= '0;
            s1_pix1_q  <= '0;
        end else begin
            s1_valid_q <= xfer;
            s1_last_q  <= xfer && last_pair;
            if (xfer) begin
                s1_pix0_q <= in_pix0;
                s1_pix1_q <= in_pix1;
            end
        end
    end

    pix_t op0, op1;

    pixel_op #(.MODE(MODE), .VALUE(VALUE), .THRESHOLD(THRESHOLD)) u_op0 (
        .pix_i (s1_pix0_q),
        .pix_o (op0)
    );

    pixel_op #(.MODE(MODE), .VALUE(VALUE), .THRESHOLD(THRESHOLD)) u_op1 (
        .pix_i (s1_pix1_q),
        .pix_o (op1)
    );

    logic hsync_q, frame_done_q;
    pix_t out0_d, out1_d, out0_q, out1_q;

    // Outputs hold the last processed pair whenever no pair is presented.
    always_comb begin
        out0_d = out0_q;
        out1_d = out1_q;
        if (s1_valid_q) begin
            out0_d = op0;
            out1_d = op1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hsync_q      <= 1'b0;
            frame_done_q <= 1'b0;
            out0_q       <= '0;
            out1_q       <= '0;
        end else begin
            hsync_q      <= s1_valid_q;
            frame_done_q <= s1_valid_q && s1_last_q;
            out0_q       <= out0_d;
            out1_q       <= out1_d;
        end
    end

    assign hsync          = hsync_q;
    assign frame_done     = frame_done_q;
    assign pixel_final_R0 = out0_q[23:16];
    assign pixel_final_G0 = out0_q[15:8];
    assign pixel_final_B0 = out0_q[7:0];
    assign pixel_final_R1 = out1_q[23:16];
    assign pixel_final_G1 = out1_q[15:8];
    assign pixel_final_B1 = out1_q[7:0];

endmodule

// File: tb/tb_image_pixel_proc.sv
// Bench for image_pixel_proc: four instances (one per mode) on shared
// stimulus, an 8x2 frame with HBLANK 4, cycle-by-cycle expected outputs.
module tb_image_pixel_proc;

    localparam int unsigned W   = 8;
    localparam int unsigned H   = 2;
    localparam int unsigned HB  = 4;
    localparam int unsigned VAL = 100;
    localparam int unsigned THR = 90;

    logic        HCLK     = 1'b0;
    logic        HRESET   = 1'b1;
    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_pix0  = '0;
    logic [23:0] in_pix1  = '0;

    logic        rdy [4];
    logic        hs  [4];
    logic        bsy [4];
    logic        fd  [4];
    logic [7:0]  r0 [4], g0 [4], b0 [4], r1 [4], g1 [4], b1 [4];
    logic [47:0] pout [4];

    int n_tests = 0;
    int n_fail  = 0;

    logic [47:0] hold [4];

    logic [23:0] tab0 [8] = '{24'h102030, 24'h000000, 24'h646464, 24'h808080,
                              24'h01FE63, 24'h5A5A5A, 24'h123456, 24'hC8320A};
    logic [23:0] tab1 [8] = '{24'hFFFFFF, 24'h9B9B9B, 24'h656463, 24'h7F7F7F,
                              24'hFE0164, 24'h0A141E, 24'h5B5A5A, 24'h5A5A5A};

    always #5 HCLK = ~HCLK;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        image_pixel_proc #(
            .width_of_image  (W),
            .height_of_image (H),
            .MODE            (m),
            .VALUE           (VAL),
            .THRESHOLD       (THR),
            .HBLANK          (HB)
        ) u_dut (
            .HCLK           (HCLK),
            .HRESET         (HRESET),
            .start          (start),
            .in_valid       (in_valid),
            .in_ready       (rdy[m]),
            .in_pix0        (in_pix0),
            .in_pix1        (in_pix1),
            .hsync          (hs[m]),
            .pixel_final_R0 (r0[m]),
            .pixel_final_G0 (g0[m]),
            .pixel_final_B0 (b0[m]),
            .pixel_final_R1 (r1[m]),
            .pixel_final_G1 (g1[m]),
            .pixel_final_B1 (b1[m]),
            .busy           (bsy[m]),
            .frame_done     (fd[m])
        );
        assign pout[m] = {r0[m], g0[m], b0[m], r1[m], g1[m], b1[m]};
    end

    task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] want);
        n_tests++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic logic [23:0] ref_pix(input int mode, input logic [23:0] p);
        int c [3];
        int s;
        logic [23:0] r;
        c[0] = int'(p[23:16]);
        c[1] = int'(p[15:8]);
        c[2] = int'(p[7:0]);
        s = c[0] + c[1] + c[2];
        if (mode == 3) return (s > int'(3 * THR)) ? 24'hFFFFFF : 24'h000000;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            int v;
            case (mode)
                0:       begin v = c[i] + int'(VAL); if (v > 255) v = 255; end
                1:       begin v = c[i] - int'(VAL); if (v < 0) v = 0; end
                default: v = 255 - c[i];
            endcase
            r[23 - 8*i -: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic check_all_zero();
        for (int m = 0; m < 4; m++) begin
            check_eq("rst_pix", pout[m], '0);
            check_eq("rst_ready", rdy[m], 1'b0);
            check_eq("rst_hsync", hs[m], 1'b0);
            check_eq("rst_busy", bsy[m], 1'b0);
            check_eq("rst_done", fd[m], 1'b0);
        end
        for (int m = 0; m < 4; m++) hold[m] = '0;
    endtask

    task automatic run_frame(input bit toggle, input int extra_start, input int abort_after,
                             input int ncyc, output int hs_cnt, output int fd_cnt,
                             output logic [12:0] rdy_vec);
        int st, col, row, bcnt, dcnt, xfers, p1i, p2i;
        bit p1v, p2v, p1l, p2l, xfer, aborted;
        logic [47:0] p1d [4];
        logic [47:0] p2d [4];
        st = 0; col = 0; row = 0; bcnt = 0; dcnt = 0; xfers = 0; p1i = 0; p2i = 0;
        p1v = 0; p2v = 0; p1l = 0; p2l = 0; aborted = 0;
        hs_cnt = 0; fd_cnt = 0; rdy_vec = '0;
        for (int m = 0; m < 4; m++) begin p1d[m] = '0; p2d[m] = '0; end
        for (int c = 0; c < ncyc; c++) begin
            @(posedge HCLK);
            #1;
            if (HRESET) HRESET = 1'b0;
            if (xfers == abort_after && !aborted) begin
                aborted = 1;
                HRESET  = 1'b1;
                #1;
                check_all_zero();
                st = 0; col = 0; row = 0;
                p1v = 0; p2v = 0; p1l = 0; p2l = 0;
            end
            if (p2v) for (int m = 0; m < 4; m++) hold[m] = p2d[m];
            for (int m = 0; m < 4; m++) begin
                check_eq("in_ready", rdy[m], st == 1);
                check_eq("busy", bsy[m], st != 0);
                check_eq("hsync", hs[m], p2v);
                check_eq("frame_done", fd[m], p2v && p2l);
                check_eq("pixels", pout[m], hold[m]);
            end
            if (p2v && p2i == 6) check_eq("thr_sum271", pout[3][23:0], 24'hFFFFFF);
            if (hs[0]) hs_cnt++;
            if (fd[0]) fd_cnt++;
            if (c >= 1 && c <= 13) rdy_vec[13 - c] = rdy[0];

            start    = (c == 0) || (c == extra_start);
            in_valid = toggle ? c[0] : 1'b1;
            in_pix0  = tab0[xfers % 8];
            in_pix1  = tab1[xfers % 8];
            xfer     = in_valid && (st == 1) && !HRESET;

            p2v = p1v; p2l = p1l; p2i = p1i;
            for (int m = 0; m < 4; m++) p2d[m] = p1d[m];
            p1v = xfer;
            p1l = xfer && (col == int'(W/2 - 1)) && (row == int'(H - 1));
            p1i = xfers % 8;
            if (xfer)
                for (int m = 0; m < 4; m++) p1d[m] = {ref_pix(m, in_pix0), ref_pix(m, in_pix1)};

            if (!HRESET) begin
                case (st)
                    0: if (start) st = 1;
                    1: if (xfer) begin
                        xfers++;
                        if (col == int'(W/2 - 1)) begin
                            col = 0;
                            if (row == int'(H - 1)) begin row = 0; st = 3; dcnt = 0; end
                            else begin row++; st = 2; bcnt = 0; end
                        end else col++;
                    end
                    2: if (bcnt == int'(HB - 1)) st = 1; else bcnt++;
                    default: if (dcnt == 1) st = 0; else dcnt++;
                endcase
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int hs_cnt, fd_cnt;
        logic [12:0] rdy_vec;

        repeat (2) @(posedge HCLK);
        #1;
        check_all_zero();
        HRESET = 1'b0;

        // Frame A: in_valid held high.
        run_frame(1'b0, -1, -1, 18, hs_cnt, fd_cnt, rdy_vec);
        check_eq("A_hs_count", hs_cnt, 8);
        check_eq("A_done_count", fd_cnt, 1);
        check_eq("A_ready_pattern", rdy_vec, 13'b1111000011110);
        check_eq("add_C8320A", pout[0][47:24], 24'hFF966E);
        check_eq("sub_C8320A", pout[1][47:24], 24'h640000);
        check_eq("inv_C8320A", pout[2][47:24], 24'h37CDF5);
        check_eq("thr_sum260", pout[3][47:24], 24'h000000);
        check_eq("thr_sum270", pout[3][23:0], 24'h000000);

        // Frame B: toggled in_valid, stray start while busy.
        run_frame(1'b1, 3, -1, 26, hs_cnt, fd_cnt, rdy_vec);
        check_eq("B_hs_count", hs_cnt, 8);
        check_eq("B_done_count", fd_cnt, 1);

        // Frame C: reset after three transfers, then idle without start.
        run_frame(1'b0, -1, 3, 12, hs_cnt, fd_cnt, rdy_vec);
        check_eq("C_hs_count", hs_cnt, 1);
        check_eq("C_done_count", fd_cnt, 0);

        // Frame D: fresh start after abort.
        run_frame(1'b0, -1, -1, 18, hs_cnt, fd_cnt, rdy_vec);
        check_eq("D_hs_count", hs_cnt, 8);
        check_eq("D_done_count", fd_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
